gcd_mmap_v2: RTL
================

Name: gcd_mmap_v2

Overview:
- Memory-mapped GCD accelerator on the PicoRV32 native memory bus; successor to the fixed 32-bit GCD peripheral.
- Adds: parametrised operand width, compile-time blocking/non-blocking Y read, sticky done/error status, iteration counter, interrupt output.
- GCD is computed only by successive subtraction, one compare/subtract per clock.
- Sits beside RAM on the CPU bus, decoded by address window.

Parameters:
- WIDTH, 32, operand/result width (2..32); wdata[WIDTH-1:0] captured, rdata zero-extended.
- CNT_W, 32, iteration counter width (1..32); counter saturates.
- BLOCKING_READ, 0, 1 = Y read stalls (ready low) while busy; 0 = Y read always returns immediately.
- MMAP_RANG, 32'h0000_ffff, address mask; offset = addr & MMAP_RANG.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- en  in  1  window select from the address decoder
- addr  in  32  byte address
- valid  in  1  bus request; master holds it until ready
- wstrb  in  4  0 = read; any nonzero = full-word write
- wdata  in  32  write data
- ready  out  1  one-cycle registered acknowledge
- rdata  out  32  read data, valid while ready=1
- irq  out  1  level interrupt = IE & DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: ready=0, rdata=0, irq=0; A, B, Y, CYCLES, IE, DONE, ERR all 0; FSM=IDLE. Reset mid-calculation aborts to IDLE next edge.
- Bus handshake:
  - A request is accepted when en&valid&!ready.
  - ready=1 for exactly one cycle, one cycle after acceptance, then 0.
  - Every access to an unmapped offset still acks: read returns 0, write is dropped. The bus never hangs.
- Register map (offsets):
  - 0x00 STATUS, R: bit0 BUSY, bit1 DONE, bit2 ERR, bit3 IE; other bits 0. Write: W1C on bit1 and bit2.
  - 0x04 Y, R: result.
  - 0x08 A, W: operand A. 0x0C B, W: operand B. Both are readable back at the same offsets.
  - 0x10 START, W: any data starts a calculation.
  - 0x14 CYCLES, R: CALC cycles used by the last operation.
  - 0x18 CTRL, R/W: bit0 IE.
- Operand registers: A and B are shadow registers. Writes while BUSY are accepted and update the shadows only; the working copies are untouched.
- FSM states: IDLE, CALC.
  - IDLE, on START accepted: load working a<=A, b<=B; CYCLES<=0; clear DONE and ERR; go to CALC.
  - CALC, if a==0 or b==0: Y<=a|b; ERR<=(a|b)==0; DONE<=1; go to IDLE.
  - CALC, else if a==b: Y<=a; DONE<=1; go to IDLE.
  - CALC, else if a>b: a<=a-b. Otherwise: b<=b-a.
  - Every CALC cycle increments CYCLES (saturating at all-ones). The final compare cycle is counted.
  - BUSY = (state==CALC).
- START while BUSY: acked and ignored; the operation in flight is unaffected.
- Y read:
  - BLOCKING_READ=0: returns current Y immediately.
  - BLOCKING_READ=1: while BUSY, the request is held un-acked. Ack comes the cycle after the FSM returns to IDLE, with the new Y.
- Simultaneous events:
  - DONE set by the FSM and a W1C clear in the same cycle: set wins.
  - START accepted and W1C in the same cycle: impossible, since one access occurs per cycle.
- Arithmetic: all WIDTH-bit unsigned. Subtraction never underflows because the larger operand is always the minuend.

Decomposition:
- Package gcd_mmap_pkg: register offsets, STATUS bit indices, FSM state encoding (IDLE, CALC).
- Sub-module gcd_core: FSM plus subtract datapath and CYCLES counter.
  - Inputs: start, a_in, b_in.
  - Outputs: busy, done_pulse, err_pulse, y, cycles.
- gcd_mmap_v2 holds the bus decode, shadow registers, STATUS/CTRL and irq.

Test Plan:
- A=12, B=18, START, poll STATUS -> Y=6, CYCLES=3, DONE=1, ERR=0, BUSY=0 after 3 CALC cycles.
- BLOCKING_READ=1, A=1, B=1000, START then immediate Y read -> ready held low for 1000 cycles, then ack with rdata=1, CYCLES=1000.
- A=0, B=7 -> Y=7, ERR=0, CYCLES=1. A=0, B=0 -> Y=0, ERR=1, DONE=1.
- CTRL.IE=1, A=48, B=36 -> irq rises with DONE (Y=12). Write STATUS=0x2 -> DONE=0, irq=0 next cycle.
- During BUSY: write A=99 and START, read 0x20 -> current result unchanged, START ignored, 0x20 read acked with 0, A reads back 99.
- rst_n low for one edge mid-CALC -> BUSY=0, Y=0, CYCLES=0, ready=0. A fresh A=9, B=6 then yields Y=3.

Source files
------------

// File: rtl/gcd_mmap_v2_pkg.sv
// GCD accelerator shared definitions: register offsets, STATUS bit positions, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package gcd_mmap_pkg;

  // Register offsets after masking with MMAP_RANG
  localparam logic [31:0] OFF_STATUS = 32'h0000_0000;
  localparam logic [31:0] OFF_Y      = 32'h0000_0004;
  localparam logic [31:0] OFF_A      = 32'h0000_0008;
  localparam logic [31:0] OFF_B      = 32'h0000_000C;
  localparam logic [31:0] OFF_START  = 32'h0000_0010;
  localparam logic [31:0] OFF_CYCLES = 32'h0000_0014;
  localparam logic [31:0] OFF_CTRL   = 32'h0000_0018;

  // STATUS bit positions
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_IE   = 3;

  // CTRL bit positions
  localparam int CTRL_IE = 0;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

endpackage

// File: rtl/gcd_mmap_v2_if.sv
// PicoRV32 native memory bus slice for one peripheral window (decoder select included).
// Latency: n/a (wiring only).
// Backpressure: master holds valid until the slave returns a one-cycle ready.
interface gcd_mmap_v2_if;
  logic        en;
  logic [31:0] addr;
  logic        valid;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output en, addr, valid, wstrb, wdata, input ready, rdata);
  modport slave  (input en, addr, valid, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/gcd_mmap_v2_core.sv
// GCD engine: repeated compare/subtract, one step per clock, with saturating step counter.
// Latency: result and done_pulse after sum-of-Euclid-quotients CALC cycles (1 if an operand is 0).
// Backpressure: start is ignored while busy; the running operation is never disturbed.
module gcd_core
  import gcd_mmap_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done_pulse,
  output logic             err_pulse,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] cycles
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  // Next-state: load working copies on start, then one compare/subtract per cycle
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    y_d        = y_q;
    cyc_d      = cyc_q;
    done_pulse = 1'b0;
    err_pulse  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          cyc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // The final compare cycle counts too, so increment unconditionally
        cyc_d = (cyc_q == {CNT_W{1'b1}}) ? cyc_q : cyc_q + 1'b1;
        if (a_q == '0 || b_q == '0) begin
          y_d        = a_q | b_q;
          done_pulse = 1'b1;
          err_pulse  = ((a_q | b_q) == '0);
          state_d    = IDLE;
        end else if (a_q == b_q) begin
          y_d        = a_q;
          done_pulse = 1'b1;
          state_d    = IDLE;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any calculation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      cyc_q   <= cyc_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign y      = y_q;
  assign cycles = cyc_q;

endmodule

// File: rtl/gcd_mmap_v2.sv
// Memory-mapped GCD peripheral: bus decode, operand shadows, STATUS/CTRL, level irq.
// Latency: every accepted access is acked one cycle later with registered ready/rdata.
// Backpressure: only a Y read with BLOCKING_READ=1 while busy is held un-acked until idle.
module gcd_mmap_v2
  import gcd_mmap_pkg::*;
#(
  parameter int          WIDTH         = 32,
  parameter int          CNT_W         = 32,
  parameter int unsigned BLOCKING_READ = 0,
  parameter logic [31:0] MMAP_RANG     = 32'h0000_ffff
) (
  input  logic          clk,
  input  logic          rst_n,
  gcd_mmap_v2_if.slave  bus,
  output logic          irq
);

  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic             ie_q, ie_d, done_q, done_d, err_q, err_d;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [31:0]      offset, status, rd_mux;
  logic             is_wr, req, y_hold, acc, wr_acc, core_start;
  logic             busy, done_pulse, err_pulse;
  logic [WIDTH-1:0] core_y;
  logic [CNT_W-1:0] core_cycles;

  gcd_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (core_start),
    .a_in       (a_sh_q),
    .b_in       (b_sh_q),
    .busy       (busy),
    .done_pulse (done_pulse),
    .err_pulse  (err_pulse),
    .y          (core_y),
    .cycles     (core_cycles)
  );

  // Bus decode: accept one request per ack, deferring blocking Y reads while busy
  always_comb begin
    offset     = bus.addr & MMAP_RANG;
    is_wr      = |bus.wstrb;
    req        = bus.en & bus.valid & ~ready_q;
    y_hold     = (BLOCKING_READ != 0) && busy && !is_wr && (offset == OFF_Y);
    acc        = req && !y_hold;
    wr_acc     = acc && is_wr;
    core_start = wr_acc && (offset == OFF_START);
  end

  // Register file update, read mux and sticky status
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    ie_d   = ie_q;
    done_d = done_q;
    err_d  = err_q;

    status          = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done_q;
    status[ST_ERR]  = err_q;
    status[ST_IE]   = ie_q;

    rd_mux = '0;
    case (offset)
      OFF_STATUS: rd_mux = status;
      OFF_Y:      rd_mux = 32'(core_y);
      OFF_A:      rd_mux = 32'(a_sh_q);
      OFF_B:      rd_mux = 32'(b_sh_q);
      OFF_CYCLES: rd_mux = 32'(core_cycles);
      OFF_CTRL:   rd_mux = {31'd0, ie_q};
      default:    rd_mux = '0;
    endcase

    // Shadows take writes at any time; the core only samples them on start
    if (wr_acc) begin
      case (offset)
        OFF_A:    a_sh_d = bus.wdata[WIDTH-1:0];
        OFF_B:    b_sh_d = bus.wdata[WIDTH-1:0];
        OFF_CTRL: ie_d   = bus.wdata[CTRL_IE];
        OFF_STATUS: begin
          if (bus.wdata[ST_DONE]) done_d = 1'b0;
          if (bus.wdata[ST_ERR])  err_d  = 1'b0;
        end
        default: ;
      endcase
    end

    // A start that the core actually takes clears the previous outcome
    if (core_start && !busy) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    // Completion beats a simultaneous W1C
    if (done_pulse) done_d = 1'b1;
    if (err_pulse)  err_d  = 1'b1;

    ready_d = acc;
    rdata_d = (acc && !is_wr) ? rd_mux : '0;
  end

  // Registered bus response and register state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign irq       = ie_q & done_q;

endmodule
